eig_host_if: RTL and testbench

Host-side front end for the eigenvalue core. Assembles a byte-serial input frame into the two signed 32-bit coefficients `a0`/`a1` and issues a one-cycle `data_rdy` launch. It then waits for the core to finish, captures `kappa`, `inv_kappa` and `regime`, and streams them back as a byte-serial result frame under valid/ready flow control. It is the initiator/consumer end of the core's launch/result interface.

---
 rtl/eig_pkg.sv | 31 +++
 rtl/eig_frame_tx.sv | 52 +++++
 rtl/eig_host_if.sv | 144 ++++++++++++++
 tb/tb_eig_host_if.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eig_pkg.sv
// Shared types and constants for the eigenvalue-core host interface.
// Frame sizes, status-byte layout and regime codes live here so both sides agree.
package eig_pkg;

  typedef enum logic [2:0] {
    StRx,
    StLaunch,
    StSettle,
    StWait,
    StTx
  } eig_if_state_t;

  localparam int unsigned IN_BYTES  = 8;
  localparam int unsigned OUT_BYTES = 9;

  localparam int unsigned STAT_ERR_BIT = 7;
  localparam int unsigned STAT_REG_LSB = 0;

  localparam logic [2:0] REG_OVER  = 3'b100;
  localparam logic [2:0] REG_CRIT  = 3'b010;
  localparam logic [2:0] REG_UNDER = 3'b001;

  function automatic logic [7:0] status_byte(input logic err, input logic [2:0] regime);
    logic [7:0] s;
    s = '0;
    s[STAT_ERR_BIT] = err;
    s[STAT_REG_LSB +: 3] = regime;
    return s;
  endfunction

endpackage

// File: rtl/eig_frame_tx.sv
// Parallel-load byte serializer for the 9-byte result frame, valid/ready on the output.
// done pulses with the handshake of the last byte.
module eig_frame_tx
  import eig_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   load,
  input  logic [OUT_BYTES*8-1:0] data,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   done
);

  localparam int unsigned IdxW = $clog2(OUT_BYTES);

  logic [OUT_BYTES-1:0][7:0] frame_q;
  logic [IdxW-1:0]           idx_q;
  logic                      active_q;
  logic                      fire;
  logic                      last;

  assign out_valid = active_q & ena;
  assign fire      = out_valid & out_ready;
  assign last      = (idx_q == IdxW'(OUT_BYTES - 1));
  assign done      = fire & last;
  assign out_byte  = frame_q[idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q  <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
    end else if (ena) begin
      if (load) begin
        frame_q  <= data;
        idx_q    <= '0;
        active_q <= 1'b1;
      end else if (fire) begin
        if (last) begin
          idx_q    <= '0;
          active_q <= 1'b0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eig_host_if.sv
// Host front end: byte-serial frame in -> a0/a1 + launch pulse, then waits for the core
// and streams status, kappa and inv_kappa back as a byte-serial frame.
module eig_host_if
  import eig_pkg::*;
#(
  parameter int unsigned MIN_LAT = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] a0,
  output logic signed [31:0] a1,
  output logic               data_rdy,
  input  logic               core_busy,
  input  logic signed [31:0] kappa,
  input  logic signed [31:0] inv_kappa,
  input  logic [2:0]         regime,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned CntMax = (MIN_LAT > TIMEOUT) ? MIN_LAT : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned RxW    = $clog2(IN_BYTES);

  eig_if_state_t            state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [RxW-1:0]           rx_cnt_q, rx_cnt_d;
  logic [IN_BYTES-1:0][7:0] rx_buf_q, rx_buf_d;
  logic [31:0]              a0_q, a0_d, a1_q, a1_d;
  logic                     err_q, err_d;
  logic                     tx_load;
  logic [OUT_BYTES*8-1:0]   tx_data;
  logic                     tx_done;

  assign a0          = a0_q;
  assign a1          = a1_q;
  assign busy        = (state_q != StRx);
  assign err_timeout = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_cnt_d = rx_cnt_q;
    rx_buf_d = rx_buf_q;
    a0_d     = a0_q;
    a1_d     = a1_q;
    err_d    = err_q;
    in_ready = 1'b0;
    data_rdy = 1'b0;
    tx_load  = 1'b0;
    tx_data  = '0;
    unique case (state_q)
      StRx: begin
        // Held off while reset is asserted so nothing is accepted before RX is established.
        in_ready = ena & rst_n;
        if (in_valid && in_ready) begin
          rx_buf_d[rx_cnt_q] = in_byte;
          if (rx_cnt_q == RxW'(IN_BYTES - 1)) begin
            a0_d     = {rx_buf_d[3], rx_buf_d[2], rx_buf_d[1], rx_buf_d[0]};
            a1_d     = {rx_buf_d[7], rx_buf_d[6], rx_buf_d[5], rx_buf_d[4]};
            rx_cnt_d = '0;
            state_d  = StLaunch;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      StLaunch: begin
        data_rdy = ena;
        err_d    = 1'b0;
        cnt_d    = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        // core_busy may still be low from the previous run; ignore it here.
        if (cnt_q == CntW'(MIN_LAT - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (!core_busy) begin
          tx_load = 1'b1;
          tx_data = {inv_kappa, kappa, status_byte(1'b0, regime)};
          state_d = StTx;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          tx_load = 1'b1;
          tx_data = {64'h0, status_byte(1'b1, regime)};
          err_d   = 1'b1;
          state_d = StTx;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTx: begin
        if (tx_done) state_d = StRx;
      end
      default: state_d = StRx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRx;
      cnt_q    <= '0;
      rx_cnt_q <= '0;
      rx_buf_q <= '0;
      a0_q     <= '0;
      a1_q     <= '0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_cnt_q <= rx_cnt_d;
      rx_buf_q <= rx_buf_d;
      a0_q     <= a0_d;
      a1_q     <= a1_d;
      err_q    <= err_d;
    end
  end

  eig_frame_tx u_frame_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (tx_load),
    .data      (tx_data),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_eig_host_if.sv
// Directed bench for eig_host_if: nominal run, stale-busy masking, backpressure,
// timeout, clock-enable freeze and reset during WAIT.
module tb_eig_host_if;

  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic [7:0]  in_byte;
  logic        in_valid, in_ready;
  logic [31:0] a0, a1;
  logic        data_rdy, core_busy;
  logic [31:0] kappa, inv_kappa;
  logic [2:0]  regime;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready;
  logic        busy, err_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_pulses = 0;

  eig_host_if #(
    .MIN_LAT (8),
    .TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a0          (a0),
    .a1          (a1),
    .data_rdy    (data_rdy),
    .core_busy   (core_busy),
    .kappa       (kappa),
    .inv_kappa   (inv_kappa),
    .regime      (regime),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_rdy) rdy_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Byte i of the frame is frame[8*i +: 8]; entered and left at (or just after) a negedge.
  task automatic send_bytes(input logic [63:0] frame, input int lo, input int hi);
    int n;
    for (int i = lo; i <= hi; i++) begin
      in_byte  = frame[8*i +: 8];
      in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_launch(input logic [31:0] ea0, input logic [31:0] ea1);
    check("launch_pulse", data_rdy, 1);
    check("a0", a0, ea0);
    check("a1", a1, ea1);
    check("busy_launch", busy, 1);
    @(negedge clk);
    check("launch_single", data_rdy, 0);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic recv_frame(input bit bp, input logic [71:0] exp, input string tag);
    bit [5:0]    pat = 6'b101001;
    logic [71:0] got = '0;
    logic [7:0]  held = '0;
    bit          stalled = 0;
    int          nb = 0, k = 0, v = 0, viol = 0;
    while (nb < 9 && k < 300) begin
      if (out_valid) begin
        if (stalled && out_byte !== held) viol++;
        out_ready = bp ? pat[v % 6] : 1'b1;
        v++;
        if (out_ready) begin
          got[8*nb +: 8] = out_byte;
          nb++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = out_byte;
        end
      end else begin
        out_ready = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check({tag, "_bytes"}, nb, 9);
    check({tag, "_frame"}, got, exp);
    check({tag, "_stall_stable"}, viol, 0);
    check({tag, "_idle_after"}, {busy, out_valid}, 2'b00);
  endtask

  initial begin
    int n;
    int p0;
    rst_n = 1'b0; ena = 1'b1; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0;
    core_busy = 1'b1; kappa = '0; inv_kappa = '0; regime = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_data_rdy", data_rdy, 0);
    check("rst_a0", a0, 0);
    check("rst_a1", a1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    #1;
    check("rx_in_ready", in_ready, 1);
    check("rx_busy", busy, 0);
    @(negedge clk);

    // Nominal: busy drops 20 cycles after data_rdy
    send_bytes(64'h00000002_00000001, 0, 7);
    check_launch(32'h1, 32'h2);
    repeat (19) @(negedge clk);
    core_busy = 1'b0; kappa = 32'h0001_8000; inv_kappa = 32'h0000_AAAA; regime = 3'b001;
    wait_out_valid(n);
    check("nom_latency", n, 1);
    recv_frame(0, {32'h0000_AAAA, 32'h0001_8000, 8'h01}, "nom");
    check("nom_err", err_timeout, 0);

    // Stale low busy must be masked through SETTLE; sink applies backpressure
    kappa = 32'h1234_5678; inv_kappa = 32'hDEAD_BEEF; regime = 3'b100;
    send_bytes(64'hFFFFFFFE_11223344, 0, 7);
    check_launch(32'h1122_3344, 32'hFFFF_FFFE);
    wait_out_valid(n);
    check("stale_latency", n, 9);
    recv_frame(1, {32'hDEAD_BEEF, 32'h1234_5678, 8'h04}, "bp");

    // Timeout: busy stuck high
    core_busy = 1'b1; regime = 3'b001; kappa = 32'h5555_5555; inv_kappa = 32'h6666_6666;
    send_bytes(64'h0000000A_00000009, 0, 7);
    check_launch(32'h9, 32'hA);
    wait_out_valid(n);
    check("to_latency", n, 72);
    recv_frame(0, {64'h0, 8'h81}, "to");
    check("to_err_set", err_timeout, 1);

    // Clock enable low mid-RX with in_valid high
    send_bytes(64'h44332211_DDCCBBAA, 0, 2);
    ena = 1'b0; in_valid = 1'b1; in_byte = 8'hEE;
    n = 0;
    repeat (5) begin
      #1;
      if (in_ready || data_rdy || out_valid || !busy === 1'b0) n++;
      @(negedge clk);
    end
    check("ena_frozen", n, 0);
    ena = 1'b1; in_valid = 1'b0;
    send_bytes(64'h44332211_DDCCBBAA, 3, 7);
    check("err_before_launch", err_timeout, 1);
    check_launch(32'hDDCC_BBAA, 32'h4433_2211);
    check("err_cleared", err_timeout, 0);

    // Reset during WAIT
    repeat (12) @(negedge clk);
    check("in_wait_busy", busy, 1);
    p0 = rdy_pulses;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("wrst_state", {busy, out_valid, in_ready}, 3'b001);
    repeat (12) @(negedge clk);
    check("wrst_no_rdy", rdy_pulses, p0);

    // Partial frame discarded by reset, then a clean frame completes
    send_bytes(64'h0, 0, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    core_busy = 1'b0; kappa = 32'hFFFF_FFFF; inv_kappa = 32'h0; regime = 3'b010;
    send_bytes(64'h80000000_7FFFFFFF, 0, 7);
    check_launch(32'h7FFF_FFFF, 32'h8000_0000);
    wait_out_valid(n);
    check("post_latency", n, 9);
    recv_frame(0, {32'h0, 32'hFFFF_FFFF, 8'h02}, "post");
    check("post_pulses", rdy_pulses, p0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
